reflet_float_div: RTL and testbench
===================================

# reflet_float_div

Iterative floating-point divider producing `in1 / in2` in the same sign/exponent/mantissa format as the rest of the FPU, sized by `float_size`. A restoring mantissa divider produces one quotient bit per clock, so the block is sequential with a start/busy/done handshake. It sits beside the combinational multiplier as the divide unit of the FPU.

## Interface
- `float_size`, 32, total float width; field widths come from `mantissa_size()`, `exponent_size()` and `exponent_bias()`. Below, M = mantissa_size, E = exponent_size.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `enable`  in  1  output gate; `div` reads 0 when low, internal state unaffected.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `in1`  in  float_size  dividend, captured on the accepting edge.
- `in2`  in  float_size  divisor, captured on the accepting edge.
- `busy`  out  1  high while in DIVIDE.
- `done`  out  1  one-cycle pulse; result valid and newly updated.
- `div`  out  float_size  result register, gated by `enable`; holds until the next completion.

## Operation
- States: IDLE, DIVIDE, DONE.
  - IDLE→DIVIDE on `start`.
  - DIVIDE→DONE when the bit counter reaches 0.
  - DONE→DIVIDE on `start`, else DONE→IDLE.
- `start` is ignored in DIVIDE. Operands are not re-sampled during an operation.
- Accept edge actions:
  - Latch sign = s1^s2.
  - Latch zero flags: `in1[float_size-2:0]==0` and `in2[float_size-2:0]==0`.
  - Load remainder = {1,mnt1} zero-extended to M+3 bits.
  - Load divisor = {1,mnt2} (M+1 bits), quotient = 0, counter = M+1.
- Each DIVIDE edge:
  - If remainder ≥ divisor: q bit = 1, subtract divisor.
  - Shift remainder left 1 and shift q bit into the LSB of the M+2-bit quotient.
  - Decrement the counter.
  - After M+2 steps, q = floor({1,mnt1}·2^(M+1) / {1,mnt2}), with q in [2^M, 2^(M+2)).
- Normalisation on the DIVIDE→DONE edge:
  - If q[M+1]=1: mantissa = q[M:1], exp = e1 − e2 + bias.
  - Else: mantissa = q[M-1:0], exp = e1 − e2 + bias − 1.
- Exponent arithmetic is done in E+2 bits and truncated to E bits. No overflow/underflow saturation and no denormals.
- Rounding is truncation; the remainder is discarded.
- Special cases, applied at the same edge and with the same latency:
  - in1 abs zero: result = {sign, 0}. This takes precedence over a zero divisor.
  - in2 abs zero and in1 non-zero: result = {sign, all-ones exponent, zero mantissa}.
- Reset, including mid-operation, aborts the operation:
  - state=IDLE, busy=0, done=0.
  - result register = 0, so `div` = 0.
  - counter and remainder cleared.

## Timing
- Accept at edge k. `busy` is high from edge k until edge k+M+2. Result and `done` are registered at edge k+M+2.
- `done` is high for exactly one cycle.
- Float32: 25 DIVIDE cycles, result visible 25 cycles after the accepting edge.
- Back-to-back: `start` held high in DONE re-enters DIVIDE at the next edge. This gives a throughput of one result per M+3 cycles.
- `div` changes only on completion or reset. `enable` acts combinationally on `div` only.

## Structure
- Field-width and bias helpers come from the shared `reflet_float_functions.vh`. No new shared constants are needed beyond the state encodings, which stay local.
- Sub-module `reflet_float_div_mantissa`, parameter `size` = M+1:
  - Unsigned restoring divider with load, step and quotient/counter outputs.
  - The top level keeps the FSM, sign/exponent path, special cases and normalisation.

## Test plan
- 6.0/2.0: start with 0x40C00000, 0x40000000 → after 25 cycles `done`=1 and `div`=0x40400000.
- 1.0/3.0: 0x3F800000, 0x40400000 → 0x3EAAAAAA (truncated). Also −1.5/0.5: 0xBFC00000, 0x3F000000 → 0xC0400000.
- Zeros:
  - 0x00000000 / 0x40000000 → 0x00000000.
  - 0x3F800000 / 0x80000000 → 0xFF800000.
  - 0x00000000 / 0x00000000 → 0x00000000.
- Handshake:
  - `start` pulsed during DIVIDE is ignored and the result matches the first operands.
  - `start` held through DONE gives a second result 26 cycles after the first.
- Reset at DIVIDE cycle 10 → `busy`=0, `done`=0 and `div`=0 immediately. A new start then completes normally with the correct value.
- `enable`=0 → `div`=0 while `done` still pulses. Raising `enable` → the held result appears combinationally.

Source files
------------

// File: rtl/reflet_float_div_pkg.sv
// Shared float-format helpers for the divide unit: field widths and
// exponent bias derived from the total float width.
package reflet_float_div_pkg;

    // Mantissa width for the supported IEEE-like formats.
    function automatic int mantissa_size(input int float_size);
        case (float_size)
            16:      return 10;
            64:      return 52;
            default: return 23;
        endcase
    endfunction

    // Exponent width is whatever is left after the sign and mantissa.
    function automatic int exponent_size(input int float_size);
        return float_size - mantissa_size(float_size) - 1;
    endfunction

    // Standard biased-exponent offset, 2^(E-1) - 1.
    function automatic int exponent_bias(input int float_size);
        return (1 << (exponent_size(float_size) - 1)) - 1;
    endfunction

endpackage

// File: rtl/reflet_float_div_mantissa.sv
// Unsigned restoring divider, one quotient bit per step. The dividend and
// divisor are both 'size' bits with a leading one; after size+1 steps the
// quotient holds floor(dividend * 2^size / divisor).
module reflet_float_div_mantissa #(
    parameter int size = 24,
    localparam int count_width = $clog2(size + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   step,
    input  logic [size-1:0]        dividend,
    input  logic [size-1:0]        divisor,
    output logic [size:0]          quotient_next,
    output logic [count_width-1:0] counter
);

    logic [size+1:0] remainder;
    logic [size-1:0] divisor_q;
    logic [size:0]   quotient;
    logic            fits;
    logic [size+1:0] reduced;

    // Trial subtraction for the current step; the quotient after this step is
    // exposed so the parent can normalise on the same edge as the last step.
    always_comb begin
        fits          = remainder >= {2'b00, divisor_q};
        reduced       = fits ? (remainder - {2'b00, divisor_q}) : remainder;
        quotient_next = {quotient[size-1:0], fits};
    end

    // Load operands on accept, otherwise advance one restoring step per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remainder <= '0;
            divisor_q <= '0;
            quotient  <= '0;
            counter   <= '0;
        end else if (load) begin
            remainder <= {2'b00, dividend};
            divisor_q <= divisor;
            quotient  <= '0;
            counter   <= count_width'(size);
        end else if (step) begin
            remainder <= reduced << 1;
            quotient  <= quotient_next;
            counter   <= counter - count_width'(1);
        end
    end

endmodule

// File: rtl/reflet_float_div.sv
// Iterative floating-point divider: in1 / in2 with a start/busy/done
// handshake. Mantissas go through a restoring divider; sign, exponent,
// zero special cases and normalisation are handled here.
module reflet_float_div
    import reflet_float_div_pkg::*;
#(
    parameter int float_size = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  start,
    input  logic [float_size-1:0] in1,
    input  logic [float_size-1:0] in2,
    output logic                  busy,
    output logic                  done,
    output logic [float_size-1:0] div
);

    localparam int M    = mantissa_size(float_size);
    localparam int E    = exponent_size(float_size);
    localparam int BIAS = exponent_bias(float_size);
    localparam int CW   = $clog2(M + 2);

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        DONE
    } state_t;

    state_t                state;
    state_t                next_state;
    logic                  accept;
    logic                  last_step;
    logic                  sign_q;
    logic                  zero1_q;
    logic                  zero2_q;
    logic [E-1:0]          exp_base_q;
    logic [float_size-1:0] result_q;
    logic [M+1:0]          quotient_next;
    logic [CW-1:0]         counter;
    logic [M-1:0]          norm_mnt;
    logic [E-1:0]          norm_exp;

    reflet_float_div_mantissa #(
        .size(M + 1)
    ) mantissa_div (
        .clk          (clk),
        .reset        (reset),
        .load         (accept),
        .step         (state == DIVIDE),
        .dividend     ({1'b1, in1[M-1:0]}),
        .divisor      ({1'b1, in2[M-1:0]}),
        .quotient_next(quotient_next),
        .counter      (counter)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start is only honoured when not dividing.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        last_step  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = DIVIDE;
                end
            end
            DIVIDE: begin
                if (counter == '0) begin
                    last_step  = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = DIVIDE;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Normalise the final quotient: it lies in [2^M, 2^(M+2)), so either the
    // top bit is the hidden one, or the one below it and the exponent drops.
    always_comb begin
        if (quotient_next[M+1]) begin
            norm_mnt = quotient_next[M:1];
            norm_exp = exp_base_q;
        end else begin
            norm_mnt = quotient_next[M-1:0];
            norm_exp = exp_base_q - E'(1);
        end
    end

    // Capture sign/exponent/zero flags on accept and write the result on the
    // last divide step. Exponent wraps modulo 2^E, so E-bit arithmetic gives
    // the same truncated value as a wider computation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign_q     <= 1'b0;
            zero1_q    <= 1'b0;
            zero2_q    <= 1'b0;
            exp_base_q <= '0;
            result_q   <= '0;
        end else begin
            if (accept) begin
                sign_q     <= in1[float_size-1] ^ in2[float_size-1];
                zero1_q    <= (in1[float_size-2:0] == '0);
                zero2_q    <= (in2[float_size-2:0] == '0);
                exp_base_q <= in1[float_size-2 -: E] - in2[float_size-2 -: E] + E'(BIAS);
            end
            if (last_step) begin
                if (zero1_q) begin
                    result_q <= {sign_q, {(float_size-1){1'b0}}};
                end else if (zero2_q) begin
                    result_q <= {sign_q, {E{1'b1}}, {M{1'b0}}};
                end else begin
                    result_q <= {sign_q, norm_exp, norm_mnt};
                end
            end
        end
    end

    // Status flags follow the state; enable only gates the visible result.
    always_comb begin
        busy = (state == DIVIDE);
        done = (state == DONE);
        div  = enable ? result_q : '0;
    end

endmodule

// File: tb/tb_reflet_float_div.sv
// Testbench for reflet_float_div (float32): table of vectors plus
// handshake/reset/enable sequences, checked through a result scoreboard.
module tb_reflet_float_div;

    localparam int FS      = 32;
    localparam int LATENCY = 25;

    typedef struct {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] expected;
    } vector_t;

    typedef struct {
        logic [31:0] result;
        int          due;
    } pending_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        start;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        busy;
    logic        done;
    logic [31:0] div;

    pending_t scoreboard[$];
    vector_t  vectors[12];
    int       checks = 0;
    int       errors = 0;
    int       cycle = 0;

    reflet_float_div #(
        .float_size(FS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .busy  (busy),
        .done  (done),
        .div   (div)
    );

    always #5 clk = ~clk;

    // Free-running cycle count used to time-stamp accepts and completions.
    always @(posedge clk) cycle <= cycle + 1;

    // Reference: integer division of the hidden-one mantissas.
    function automatic logic [31:0] model_div(input logic [31:0] a, input logic [31:0] b);
        logic        sign;
        logic [63:0] na;
        logic [63:0] nb;
        logic [63:0] q;
        logic [7:0]  e;
        sign = a[31] ^ b[31];
        if (a[30:0] == 31'd0) return {sign, 31'd0};
        if (b[30:0] == 31'd0) return {sign, 8'hFF, 23'd0};
        na = {40'd0, 1'b1, a[22:0]};
        nb = {40'd0, 1'b1, b[22:0]};
        q  = (na << 24) / nb;
        e  = a[30:23] - b[30:23] + 8'd127;
        if (q[24]) return {sign, e, q[23:1]};
        return {sign, e - 8'd1, q[22:0]};
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one request; the scoreboard entry is stamped with its due cycle.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] expected, input bit hold,
                                  output int accept_cycle);
        pending_t p;
        @(negedge clk);
        in1   = a;
        in2   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        accept_cycle = cycle;
        if (!hold) start = 1'b0;
        p.result = expected;
        p.due    = accept_cycle + LATENCY;
        scoreboard.push_back(p);
    endtask

    // Bounded wait for all outstanding results to come back.
    task automatic wait_drain();
        for (int i = 0; i < 120; i++) begin
            if (scoreboard.size() == 0) break;
            @(posedge clk);
        end
        #1;
        check_output("drain", scoreboard.size(), 0);
        @(negedge clk);
        @(negedge clk);
    endtask

    // Monitor: compare every completion against the scoreboard head.
    initial begin
        bit       pulse_seen;
        pending_t p;
        pulse_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (pulse_seen) check_output("done_pulse", {31'd0, done}, 32'd0);
            pulse_seen = 1'b0;
            if (!reset && done) begin
                if (scoreboard.size() == 0) begin
                    check_output("unexpected_done", div, 32'hDEAD_BEEF);
                end else begin
                    p = scoreboard.pop_front();
                    check_output("result", div, enable ? p.result : 32'd0);
                    check_output("latency", cycle, p.due);
                    check_output("busy_at_done", {31'd0, busy}, 32'd0);
                end
                pulse_seen = 1'b1;
            end
        end
    end

    initial begin
        int          acc;
        logic [31:0] ra;
        logic [31:0] rb;
        pending_t    p;

        reset  = 1'b1;
        enable = 1'b1;
        start  = 1'b0;
        in1    = '0;
        in2    = '0;

        vectors[0] = '{32'h40C00000, 32'h40000000, 32'h40400000};
        vectors[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA};
        vectors[2] = '{32'hBFC00000, 32'h3F000000, 32'hC0400000};
        vectors[3] = '{32'h00000000, 32'h40000000, 32'h00000000};
        vectors[4] = '{32'h3F800000, 32'h80000000, 32'hFF800000};
        vectors[5] = '{32'h00000000, 32'h00000000, 32'h00000000};
        vectors[6] = '{32'h3FFFFFFF, 32'h3F800001, 32'h3FFFFFFD};
        for (int i = 7; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom;
            vectors[i] = '{ra, rb, model_div(ra, rb)};
        end

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_busy", {31'd0, busy}, 32'd0);
        check_output("reset_done", {31'd0, done}, 32'd0);
        check_output("reset_div", div, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vectors[i].in1, vectors[i].in2, vectors[i].expected, 1'b0, acc);
            repeat (5) @(posedge clk);
            #1;
            check_output("busy_mid", {31'd0, busy}, 32'd1);
            wait_drain();
        end

        $display("[TB] start ignored during divide");
        apply_stimulus(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, acc);
        repeat (5) @(negedge clk);
        in1   = 32'h3F800000;
        in2   = 32'h40400000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        $display("[TB] back-to-back with start held");
        apply_stimulus(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b1, acc);
        in1 = 32'hBFC00000;
        in2 = 32'h3F000000;
        p.result = 32'hC0400000;
        p.due    = acc + LATENCY + LATENCY + 1;
        scoreboard.push_back(p);
        repeat (30) @(negedge clk);
        start = 1'b0;
        wait_drain();

        $display("[TB] reset during divide");
        apply_stimulus(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, acc);
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_output("abort_busy", {31'd0, busy}, 32'd0);
        check_output("abort_done", {31'd0, done}, 32'd0);
        check_output("abort_div", div, 32'd0);
        scoreboard.delete();
        @(negedge clk);
        reset = 1'b0;
        apply_stimulus(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, acc);
        wait_drain();

        $display("[TB] enable gating");
        enable = 1'b0;
        apply_stimulus(32'hBFC00000, 32'h3F000000, 32'hC0400000, 1'b0, acc);
        wait_drain();
        check_output("gated_div", div, 32'd0);
        enable = 1'b1;
        #1;
        check_output("ungated_div", div, 32'hC0400000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
